// File: rtl/exe_div_if.sv
// Operand/result bundle between the EX stage and the iterative divider.
// The EX stage is the master: it presents the decoded DIV/DIVU request and
// operands, and receives the stall request and the HI/LO result.
interface exe_div_if;
    logic        start_i;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        stall_req_o;
    logic        ready_o;
    logic [31:0] div_hi_o;
    logic [31:0] div_lo_o;

    modport master (
        output start_i, signed_i, dividend_i, divisor_i,
        input  stall_req_o, ready_o, div_hi_o, div_lo_o
    );

    modport slave (
        input  start_i, signed_i, dividend_i, divisor_i,
        output stall_req_o, ready_o, div_hi_o, div_lo_o
    );
endinterface

// File: rtl/exe_div.sv
// Iterative 32-bit MIPS DIV/DIVU unit for the EX stage.
// Radix-2 restoring division, one quotient bit per cycle. The remainder
// goes to HI and the quotient to LO; the pipeline is frozen through
// stall_req_o while the divide runs.
module exe_div (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush_i,
    input  logic      stall_i,
    exe_div_if.slave  div_if
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] work_q, work_d;      // {remainder, quotient}
    logic [31:0] divisor_q, divisor_d;
    logic        quo_neg_q, quo_neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        ready_q;

    // Operand magnitudes; abs is only taken for the signed flavour.
    logic        dvd_neg, dvs_neg;
    logic [31:0] dvd_abs, dvs_abs;

    assign dvd_neg = div_if.signed_i & div_if.dividend_i[31];
    assign dvs_neg = div_if.signed_i & div_if.divisor_i[31];
    assign dvd_abs = dvd_neg ? (32'd0 - div_if.dividend_i) : div_if.dividend_i;
    assign dvs_abs = dvs_neg ? (32'd0 - div_if.divisor_i)  : div_if.divisor_i;

    // One restoring step: shift {rem,quo} left, subtract the divisor from the
    // 33-bit partial remainder if it fits and shift a 1 into the quotient.
    logic [64:0] shifted;
    logic        fits;
    logic [31:0] rem_sub;
    logic [63:0] step;

    always_comb begin
        shifted = {work_q, 1'b0};
        fits    = (shifted[64:32] >= {1'b0, divisor_q});
        // The difference is below the divisor, so its low 32 bits are exact.
        rem_sub = shifted[63:32] - divisor_q;
        if (fits) begin
            step = {rem_sub, shifted[31:1], 1'b1};
        end else begin
            step = shifted[63:0];
        end
    end

    // Next-state and datapath update; flush aborts from any state.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (div_if.start_i) begin
                        if (div_if.divisor_i == 32'd0) begin
                            // Divide by zero: no trap, fixed result pattern.
                            lo_d    = 32'hFFFF_FFFF;
                            hi_d    = div_if.dividend_i;
                            state_d = S_DONE;
                        end else begin
                            work_d    = {32'd0, dvd_abs};
                            divisor_d = dvs_abs;
                            quo_neg_d = dvd_neg ^ dvs_neg;
                            rem_neg_d = dvd_neg;
                            cnt_d     = 6'd0;
                            state_d   = S_DIV;
                        end
                    end
                end
                S_DIV: begin
                    if (!div_if.start_i) begin
                        // Instruction left EX: abandon without touching HI/LO.
                        state_d = S_IDLE;
                    end else begin
                        work_d = step;
                        cnt_d  = cnt_q + 6'd1;
                        if (cnt_q == 6'd31) begin
                            lo_d    = quo_neg_q ? (32'd0 - step[31:0])  : step[31:0];
                            hi_d    = rem_neg_q ? (32'd0 - step[63:32]) : step[63:32];
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // Held start_i is ignored here; leave once downstream accepts.
                    if (!stall_i) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 6'd0;
            work_q    <= 64'd0;
            divisor_q <= 32'd0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            ready_q   <= (state_d == S_DONE);
        end
    end

    assign div_if.stall_req_o = ((state_q == S_IDLE) & div_if.start_i & ~flush_i)
                              | (state_q == S_DIV);
    assign div_if.ready_o     = ready_q;
    assign div_if.div_hi_o    = hi_q;
    assign div_if.div_lo_o    = lo_q;

endmodule

// File: tb/tb_exe_div.sv
// Bench for exe_div: a driver issues directed divides and pushes the expected
// {hi, lo} into a scoreboard queue; a monitor pops and compares on every
// rising edge of ready_o. Timing (stall window, latency, hold) is checked
// by the driver.
module tb_exe_div;
    logic clk;
    logic rst;
    logic flush_i;
    logic stall_i;

    exe_div_if dif ();

    exe_div dut (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_i),
        .stall_i (stall_i),
        .div_if  (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] sb_q[$];   // expected {hi, lo}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare each completed result against the scoreboard.
    initial begin
        logic        ready_prev;
        logic [63:0] exp;
        ready_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (dif.ready_o === 1'b1 && !ready_prev) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    exp = sb_q.pop_front();
                    check("div_hi", dif.div_hi_o, exp[63:32]);
                    check("div_lo", dif.div_lo_o, exp[31:0]);
                end
            end
            ready_prev = (dif.ready_o === 1'b1);
        end
    end

    // Issue one divide, verify stall window and latency, hold DONE with
    // stall_i for 'hold' cycles, then retire the instruction.
    task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                           input int lat, input int hold);
        int cyc;
        int stalls;
        sb_q.push_back({exp_hi, exp_lo});
        @(posedge clk);
        #1;
        dif.start_i    = 1'b1;
        dif.signed_i   = sg;
        dif.dividend_i = a;
        dif.divisor_i  = b;
        stall_i        = (hold > 0);
        cyc    = 0;
        stalls = 0;
        while (cyc < 100) begin
            @(negedge clk);
            if (dif.stall_req_o) stalls++;
            if (dif.ready_o) break;
            cyc++;
        end
        check("latency", cyc, lat);
        check("stall_req_cycles", stalls, lat);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (i == hold - 1) stall_i = 1'b0;
            @(negedge clk);
            check("ready_held", dif.ready_o, 1'b1);
            check("stall_req_in_done", dif.stall_req_o, 1'b0);
        end
        @(posedge clk);
        #1;
        dif.start_i = 1'b0;
        @(negedge clk);
        check("ready_drop", dif.ready_o, 1'b0);
        check("stall_req_idle", dif.stall_req_o, 1'b0);
    endtask

    // Start a divide and abort it after 'after' cycles with flush or reset.
    task automatic abort_div(input logic use_rst, input int after);
        @(posedge clk);
        #1;
        dif.start_i    = 1'b1;
        dif.signed_i   = 1'b0;
        dif.dividend_i = 32'd1000;
        dif.divisor_i  = 32'd3;
        repeat (after) @(posedge clk);
        #1;
        if (use_rst) begin
            rst         = 1'b1;
            dif.start_i = 1'b0;
        end else begin
            flush_i = 1'b1;
        end
        @(posedge clk);
        #1;
        rst         = 1'b0;
        flush_i     = 1'b0;
        dif.start_i = 1'b0;
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        flush_i        = 1'b0;
        stall_i        = 1'b0;
        dif.start_i    = 1'b0;
        dif.signed_i   = 1'b0;
        dif.dividend_i = 32'd0;
        dif.divisor_i  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", dif.ready_o, 1'b0);
        check("reset_stall_req", dif.stall_req_o, 1'b0);
        check("reset_hi", dif.div_hi_o, 32'd0);
        check("reset_lo", dif.div_lo_o, 32'd0);

        // Unsigned and signed quotient/remainder sign combinations.
        run_div(1'b0, 32'd100,         32'd7,         32'd14,        32'd2,         33, 0);
        run_div(1'b1, 32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 0);
        run_div(1'b1, 32'd7,           32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         33, 0);
        run_div(1'b1, 32'hFFFF_FF9C,   32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE, 33, 0);
        run_div(1'b1, 32'h8000_0000,   32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         33, 0);
        run_div(1'b0, 32'hFFFF_FFFF,   32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF, 33, 0);
        // Divide by zero completes after one cycle.
        run_div(1'b0, 32'd5,           32'd0,         32'hFFFF_FFFF, 32'd5,          1, 0);

        // Flush at N+10: back to IDLE, no completion, HI/LO untouched.
        abort_div(1'b0, 10);
        @(negedge clk);
        check("flush_ready", dif.ready_o, 1'b0);
        check("flush_stall_req", dif.stall_req_o, 1'b0);
        check("flush_hold_hi", dif.div_hi_o, 32'd5);
        check("flush_hold_lo", dif.div_lo_o, 32'hFFFF_FFFF);
        run_div(1'b0, 32'd9,           32'd3,         32'd3,         32'd0,         33, 0);

        // Completed result held under downstream stall for 3 cycles.
        run_div(1'b0, 32'd50,          32'd5,         32'd10,        32'd0,         33, 3);

        // Reset mid-divide clears everything.
        abort_div(1'b1, 5);
        @(negedge clk);
        check("rst_ready", dif.ready_o, 1'b0);
        check("rst_stall_req", dif.stall_req_o, 1'b0);
        check("rst_hi", dif.div_hi_o, 32'd0);
        check("rst_lo", dif.div_lo_o, 32'd0);
        run_div(1'b0, 32'hFFFF_FFFF,   32'd1,         32'hFFFF_FFFF, 32'd0,         33, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/exe_div.md
# exe_div

Iterative 32-bit divider for the EX stage; consumes the operand and control outputs of the ID→EX pipeline register (`exe_reg1_o`, `exe_reg2_o`, decoded DIV/DIVU) and drives the stall request back to the pipeline controller that holds the ID→EX register. Implements MIPS DIV/DIVU with a radix-2 restoring algorithm, one quotient bit per cycle. Results go to HI (remainder) and LO (quotient) through the EX-stage hi/lo write path.

## Interface
No parameters; width fixed at 32 bits.
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush_i  in  1  pipeline flush (exception/eret); aborts any operation
- stall_i  in  1  downstream stall (EX/MEM or later cannot accept); holds completed result
- start_i  in  1  EX instruction is DIV/DIVU; held high by EX until the instruction leaves EX
- signed_i  in  1  1 = DIV, 0 = DIVU; sampled with operands
- dividend_i  in  32  rs value (`exe_reg1_o`)
- divisor_i  in  32  rt value (`exe_reg2_o`)
- stall_req_o  out  1  request to freeze IF/ID/ID→EX while division runs
- ready_o  out  1  result valid on `div_hi_o`/`div_lo_o`
- div_hi_o  out  32  remainder
- div_lo_o  out  32  quotient

## Operation
- States: IDLE, DIV, DONE. Reset/flush → IDLE.
- IDLE: if start_i=1 and divisor_i≠0: latch |dividend|, |divisor| (abs only when signed_i=1), latch quotient-negate = signed_i & (sign(dividend) ^ sign(divisor)), remainder-negate = signed_i & sign(dividend); clear 6-bit counter; → DIV.
- IDLE, start_i=1, divisor_i=0: div_lo_o ← 32'hFFFF_FFFF, div_hi_o ← dividend_i; → DONE.
- DIV: 64-bit work reg {rem,quo}; each cycle shift left 1, trial = rem[32:0] − {1'b0,divisor}; if trial ≥ 0, rem ← trial, quo[0] ← 1. Counter increments; after 32nd iteration apply sign fixups (two's-complement negate) into div_lo_o/div_hi_o; → DONE.
- DONE: ready_o=1. If stall_i=0 → IDLE; if stall_i=1 stay DONE (no restart on held start_i).
- start_i dropping to 0 in DIV → IDLE, outputs unchanged, ready_o stays 0.
- flush_i has priority over every other condition in every state; rst priority over flush_i.
- Signed 0x8000_0000 / 0xFFFF_FFFF yields lo=0x8000_0000, hi=0 (natural wrap, no trap).
- div_hi_o/div_lo_o hold last completed values until next completion.

## Timing
- Reset values: state IDLE, stall_req_o=0, ready_o=0, div_hi_o=0, div_lo_o=0, counter=0.
- stall_req_o combinational: (IDLE & start_i & ~flush_i) | DIV. Never high in DONE.
- ready_o registered: 1 exactly while in DONE.
- Nonzero divisor, start sampled in IDLE at cycle N: DIV cycles N+1..N+32, DONE at N+33; stall_req_o high N..N+32 (33 cycles).
- Divisor zero: DONE at N+1; stall_req_o high only in cycle N.
- Back-to-back divides: DONE at M, stall_i=0 → IDLE at M+1; new start_i accepted at M+1 (≥1 idle cycle between operations).
- Flush in cycle K (any state) → IDLE at K+1, ready_o=0 at K+1.

## Test plan
- DIVU 100 / 7 at cycle N → stall_req_o high N..N+32, ready_o at N+33, lo=14, hi=2.
- DIV −7 (0xFFFF_FFF9) / 2 → lo=0xFFFF_FFFD (−3), hi=0xFFFF_FFFF (−1); DIV 7 / −2 → lo=−3, hi=1; DIV 0x8000_0000 / −1 → lo=0x8000_0000, hi=0.
- DIVU 5 / 0 → ready_o at N+1, lo=0xFFFF_FFFF, hi=5, stall_req_o single cycle.
- Flush asserted at N+10 of a running divide → IDLE at N+11, ready_o never asserts, outputs keep previous result; new DIVU 9/3 right after completes lo=3, hi=0.
- Done with stall_i=1 for 3 cycles → ready_o held 4 cycles, no restart, stall_req_o=0 throughout; then IDLE.
- rst asserted mid-DIV → all outputs 0 next cycle; DIVU 0xFFFF_FFFF / 1 → lo=0xFFFF_FFFF, hi=0.
